// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared constants for io_port_bank.
//   Offset helpers place the key level, press-flag and first duty register directly after the
//   N_OUT output port registers inside the 16-byte I/O window.
//   RD_DEFAULT is returned for window misses and unmapped offsets.
package io_bank_pkg;

   localparam logic [7:0] RD_DEFAULT = 8'hFF;

   function automatic logic [3:0] off_keylvl(input int unsigned n_out);
      return 4'(n_out);
   endfunction

   function automatic logic [3:0] off_keyflg(input int unsigned n_out);
      return 4'(n_out + 1);
   endfunction

   function automatic logic [3:0] off_duty0(input int unsigned n_out);
      return 4'(n_out + 2);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one active-low asynchronous key -> debounced active-high level.
//   Ports:
//     clock    in  system clock
//     reset    in  synchronous, active-high
//     key_raw  in  asynchronous key, 0 = pressed
//     level    out debounced level, 1 = pressed
//     rise     out one-cycle pulse on the edge where level goes 0 -> 1
//   A new synchronised level must hold for DEB_CYC consecutive cycles before it is accepted.
module key_debounce #(
   parameter int unsigned DEB_CYC = 250000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEB_CYC);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

   logic [1:0]    sync_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;
   logic          pressed;
   logic          accept;

   // Synchroniser resets to the released level so an idle key never starts a count.
   assign pressed = ~sync_q[1];
   assign accept  = (pressed != stable_q) && (cnt_q == LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= 2'b11;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q <= {sync_q[0], key_raw};
         if (pressed == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LAST) begin
            stable_q <= pressed;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign level = stable_q;
   assign rise  = accept & pressed;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O peripheral on the coremax2 CPU bus.
//   Ports:
//     clock     in  system clock
//     reset     in  synchronous, active-high
//     address   in  CPU address; window hit when address[15:4] == BASE[15:4]
//     wdata     in  CPU write data
//     we        in  write strobe
//     rdata     out registered read data (1-cycle latency, 8'hFF on miss/unmapped)
//     key_raw   in  active-low asynchronous keys
//     port_out  out output ports, port i on [8i+7:8i]
//   Map: 0..N_OUT-1 ports (R/W), N_OUT key level (RO), N_OUT+1 press flags (W1C),
//        N_OUT+2+i duty of port i (only with IO_BANK_PWM_EN).
//   Optional feature: define IO_BANK_PWM_EN for per-port PWM dimming.
module io_port_bank
   import io_bank_pkg::*;
#(
   parameter logic [15:0] BASE     = 16'hFF00,
   parameter int unsigned N_OUT    = 2,
   parameter int unsigned N_KEY    = 4,
   parameter int unsigned DEB_CYC  = 250000,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [15:0]          address,
   input  logic [7:0]           wdata,
   input  logic                 we,
   output logic [7:0]           rdata,
   input  logic [N_KEY-1:0]     key_raw,
   output logic [8*N_OUT-1:0]   port_out
);

   localparam logic [3:0] OFF_KEYLVL = off_keylvl(N_OUT);
   localparam logic [3:0] OFF_KEYFLG = off_keyflg(N_OUT);

   logic                  hit;
   logic [3:0]            off;
   logic                  wr;
   logic [N_OUT-1:0][7:0] port_q;
   logic [N_KEY-1:0]      key_lvl;
   logic [N_KEY-1:0]      key_rise;
   logic [N_KEY-1:0]      flag_q;
   logic [N_KEY-1:0]      flag_clr;
   logic [7:0]            rd_d;

   assign hit = (address[15:4] == BASE[15:4]);
   assign off = address[3:0];
   assign wr  = we & hit;

   for (genvar k = 0; k < N_KEY; k++) begin : g_key
      key_debounce #(
         .DEB_CYC (DEB_CYC)
      ) u_deb (
         .clock   (clock),
         .reset   (reset),
         .key_raw (key_raw[k]),
         .level   (key_lvl[k]),
         .rise    (key_rise[k])
      );
   end

   assign flag_clr = (wr && off == OFF_KEYFLG) ? wdata[N_KEY-1:0] : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         port_q <= '0;
         flag_q <= '0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (wr && off == 4'(i)) port_q[i] <= wdata;
         end
         // A press landing on the same edge as its clear must not be lost.
         flag_q <= (flag_q & ~flag_clr) | key_rise;
      end
   end

`ifdef IO_BANK_PWM_EN
   localparam logic [3:0] OFF_DUTY0 = off_duty0(N_OUT);

   logic [N_OUT-1:0][7:0] duty_q;
   logic [PWM_BITS-1:0]   pwm_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         duty_q    <= '1;
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
         for (int i = 0; i < N_OUT; i++) begin
            if (wr && off == OFF_DUTY0 + 4'(i)) duty_q[i] <= wdata;
         end
      end
   end

   // All-ones duty means fully on, so the counter's top value is covered too.
   always_comb begin
      port_out = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (duty_q[i][PWM_BITS-1:0] == '1 || pwm_cnt_q < duty_q[i][PWM_BITS-1:0]) begin
            port_out[8*i +: 8] = port_q[i];
         end
      end
   end
`else
   assign port_out = port_q;
`endif

   always_comb begin
      rd_d = RD_DEFAULT;
      if (hit) begin
         for (int i = 0; i < N_OUT; i++) begin
            if (off == 4'(i)) rd_d = port_q[i];
         end
         if (off == OFF_KEYLVL) begin
            rd_d = '0;
            rd_d[N_KEY-1:0] = key_lvl;
         end
         if (off == OFF_KEYFLG) begin
            rd_d = '0;
            rd_d[N_KEY-1:0] = flag_q;
         end
`ifdef IO_BANK_PWM_EN
         for (int i = 0; i < N_OUT; i++) begin
            if (off == OFF_DUTY0 + 4'(i)) rd_d = duty_q[i];
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) rdata <= '0;
      else       rdata <= rd_d;
   end

endmodule
